// File: rtl/write_eeprom_if.sv
// I2C master command bus shared by the EEPROM read/write controllers.
// The master modport is taken by the controller that issues transactions.
interface write_eeprom_if;
   logic [6:0] i2c_slave_addr;
   logic       i2c_rw;
   logic [7:0] i2c_write_data;
   logic [7:0] i2c_nbytes;
   logic       i2c_start;
   logic       i2c_tx_data_req;
   logic       i2c_busy;
   logic       i2c_nack;

   modport master (
      output i2c_slave_addr, i2c_rw, i2c_write_data, i2c_nbytes, i2c_start,
      input  i2c_tx_data_req, i2c_busy, i2c_nack
   );

   modport slave (
      input  i2c_slave_addr, i2c_rw, i2c_write_data, i2c_nbytes, i2c_start,
      output i2c_tx_data_req, i2c_busy, i2c_nack
   );
endinterface

// File: rtl/write_eeprom.sv
// Page-splitting write controller for 24xx-style I2C EEPROMs.
// Define WR_ACK_POLL_EN to replace the fixed write-cycle wait with ACK polling (TWR_CYCLES becomes a timeout).
module write_eeprom #(
   parameter int unsigned PAGE_SIZE  = 64,
   parameter int unsigned TWR_CYCLES = 250000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [6:0]  slave_addr_w,
   input  logic [15:0] mem_addr_w,
   input  logic [7:0]  write_nbytes_w,
   input  logic        start,
   input  logic [7:0]  data_in,
   input  logic        data_in_valid,
   output logic        data_in_ready,
   output logic        busy,
   output logic        done,
   output logic        underrun,
   write_eeprom_if.master i2c
);
   typedef enum logic [2:0] {IDLE, CHUNK, SEND, WAIT_END, WRITE_CYCLE, DONE} state_t;

   localparam logic [7:0]  PAGE_MASK = 8'(PAGE_SIZE - 1);
   localparam logic [8:0]  PAGE_SPAN = 9'(PAGE_SIZE);
   localparam logic [31:0] TWR_LAST  = 32'(TWR_CYCLES - 1);

   state_t      state;
   logic [6:0]  slave_addr_r;
   logic [15:0] mem_addr_r;
   logic [7:0]  remaining;
   logic [7:0]  chunk;
   logic [7:0]  byte_idx;
   logic [7:0]  total;
   logic [8:0]  loaded;
   logic        data_sent;
   logic        hold_full;
   logic [7:0]  hold_data;
   logic [31:0] timer;

   logic [8:0]  page_space;
   logic [7:0]  chunk_calc;
   logic        start_acc, fill, slot, drain, skip, full_n, page_done;
   logic [8:0]  loaded_n;
   logic [7:0]  total_n;

`ifdef WR_ACK_POLL_EN
   logic [1:0]  poll_phase;
   logic        poll_ack;
   assign poll_ack = (poll_phase == 2'd2) && !i2c.i2c_busy && !i2c.i2c_nack;
   assign page_done = (state == WRITE_CYCLE) && (poll_ack || (timer == TWR_LAST));
`else
   logic unused_nack;
   assign unused_nack = i2c.i2c_nack;
   assign page_done = (state == WRITE_CYCLE) && (timer == TWR_LAST);
`endif

   // A transaction never crosses a page: bytes left in the current page bound the chunk.
   always_comb begin
      page_space = PAGE_SPAN - {1'b0, mem_addr_r[7:0] & PAGE_MASK};
      chunk_calc = ({1'b0, remaining} < page_space) ? remaining : page_space[7:0];
   end

   // Holding-register bookkeeping; an underrun slot is counted as loaded so later bytes stay aligned.
   always_comb begin
      start_acc = (state == IDLE) && start;
      fill      = data_in_valid && data_in_ready;
      slot      = (state == SEND) && !data_sent && i2c.i2c_tx_data_req && (byte_idx >= 8'd2);
      drain     = slot && hold_full;
      skip      = slot && !hold_full;
      if (start_acc) begin
         total_n  = write_nbytes_w;
         loaded_n = '0;
         full_n   = 1'b0;
      end else begin
         total_n  = total;
         loaded_n = loaded + {8'd0, fill} + {8'd0, skip};
         full_n   = (hold_full && !drain) || fill;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state              <= IDLE;
         busy               <= 1'b0;
         done               <= 1'b0;
         underrun           <= 1'b0;
         data_in_ready      <= 1'b0;
         i2c.i2c_start      <= 1'b0;
         i2c.i2c_nbytes     <= '0;
         i2c.i2c_slave_addr <= '0;
         i2c.i2c_rw         <= 1'b0;
         i2c.i2c_write_data <= '0;
         remaining          <= '0;
         chunk              <= '0;
         byte_idx           <= '0;
         total              <= '0;
         loaded             <= '0;
         data_sent          <= 1'b0;
         hold_full          <= 1'b0;
         timer              <= '0;
`ifdef WR_ACK_POLL_EN
         poll_phase         <= '0;
`endif
      end else begin
         i2c.i2c_start <= 1'b0;
         i2c.i2c_rw    <= 1'b0;
         done          <= 1'b0;
         total         <= total_n;
         loaded        <= loaded_n;
         hold_full     <= full_n;
         if (fill) hold_data <= data_in;
         data_in_ready <= !full_n && (loaded_n < {1'b0, total_n}) &&
                          (((state != IDLE) && (state != DONE)) || start_acc);
         if (!i2c.i2c_tx_data_req) data_sent <= 1'b0;

         case (state)
            IDLE: begin
               if (start) begin
                  slave_addr_r <= slave_addr_w;
                  mem_addr_r   <= mem_addr_w;
                  remaining    <= write_nbytes_w;
                  underrun     <= 1'b0;
                  busy         <= 1'b1;
                  state        <= (write_nbytes_w == 8'd0) ? DONE : CHUNK;
               end
            end
            CHUNK: begin
               chunk              <= chunk_calc;
               i2c.i2c_nbytes     <= chunk_calc + 8'd2;
               i2c.i2c_slave_addr <= slave_addr_r;
               i2c.i2c_start      <= 1'b1;
               byte_idx           <= '0;
               data_sent          <= 1'b0;
               state              <= SEND;
            end
            SEND: begin
               if (!data_sent && i2c.i2c_tx_data_req) begin
                  data_sent <= 1'b1;
                  byte_idx  <= byte_idx + 8'd1;
                  if (byte_idx == 8'd0)
                     i2c.i2c_write_data <= mem_addr_r[15:8];
                  else if (byte_idx == 8'd1)
                     i2c.i2c_write_data <= mem_addr_r[7:0];
                  else if (hold_full)
                     i2c.i2c_write_data <= hold_data;
                  else begin
                     i2c.i2c_write_data <= 8'hFF;
                     underrun           <= 1'b1;
                  end
                  if (byte_idx == chunk + 8'd1) state <= WAIT_END;
               end
            end
            WAIT_END: begin
               if (!i2c.i2c_busy) begin
                  timer <= '0;
`ifdef WR_ACK_POLL_EN
                  poll_phase <= '0;
`endif
                  state <= WRITE_CYCLE;
               end
            end
            WRITE_CYCLE: begin
               if (page_done) begin
                  mem_addr_r <= mem_addr_r + {8'd0, chunk};
                  remaining  <= remaining - chunk;
                  state      <= (remaining == chunk) ? DONE : CHUNK;
`ifdef WR_ACK_POLL_EN
                  if (!poll_ack) underrun <= 1'b1;
`endif
               end else begin
                  timer <= timer + 32'd1;
`ifdef WR_ACK_POLL_EN
                  // Address-only write; a NACK means the internal write cycle is still running.
                  case (poll_phase)
                     2'd0: begin
                        i2c.i2c_nbytes     <= 8'd0;
                        i2c.i2c_slave_addr <= slave_addr_r;
                        i2c.i2c_start      <= 1'b1;
                        poll_phase         <= 2'd1;
                     end
                     2'd1:    poll_phase <= 2'd2;
                     default: if (!i2c.i2c_busy) poll_phase <= 2'd0;
                  endcase
`endif
               end
            end
            DONE: begin
               done  <= 1'b1;
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_write_eeprom.sv
// Bench for write_eeprom: behavioural I2C master, payload producer and a page-splitting reference model.
module tb_write_eeprom;
   localparam int PAGE = 8;
   localparam int TWR  = 12;

   logic        clk = 1'b0;
   logic        reset;
   logic [6:0]  slave_addr_w;
   logic [15:0] mem_addr_w;
   logic [7:0]  write_nbytes_w;
   logic        start;
   logic [7:0]  data_in;
   logic        data_in_valid;
   logic        data_in_ready, busy, done, underrun;

   write_eeprom_if bus();

   write_eeprom #(.PAGE_SIZE(PAGE), .TWR_CYCLES(TWR)) dut (
      .clk(clk), .reset(reset),
      .slave_addr_w(slave_addr_w), .mem_addr_w(mem_addr_w), .write_nbytes_w(write_nbytes_w),
      .start(start), .data_in(data_in), .data_in_valid(data_in_valid), .data_in_ready(data_in_ready),
      .busy(busy), .done(done), .underrun(underrun), .i2c(bus)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   logic [7:0] pay [256];
   int         pay_n = 0, pidx = 0;
   bit         feed_en = 1'b0;
   bit         rdy_q;
   int         exp_n[$];
   logic [7:0] exp_data[$];
   int         got_n[$], got_sa[$], got_rw[$];
   logic [7:0] got_data[$];
   int         cyc = 0, fall_cyc = 0, done_cnt = 0;
   bit         pend_page = 1'b0;

   // Behavioural I2C master: level request per byte, busy for the whole transaction.
   initial begin : bfm
      int st, gap, nb, tail, cur_n;
      st = 0; gap = 0; nb = 0; tail = 0; cur_n = 0;
      bus.i2c_busy = 1'b0; bus.i2c_tx_data_req = 1'b0; bus.i2c_nack = 1'b0;
      forever begin
         @(negedge clk);
         cyc++;
         if (reset) begin
            st = 0; bus.i2c_busy = 1'b0; bus.i2c_tx_data_req = 1'b0; pend_page = 1'b0;
         end else begin
            if (done) begin
               done_cnt++;
               if (pend_page) chk("done_delay", cyc - fall_cyc, TWR + 2);
               pend_page = 1'b0;
            end
            case (st)
               0: if (bus.i2c_start) begin
                  if (pend_page) chk("page_gap", cyc - fall_cyc, TWR + 2);
                  pend_page = 1'b0;
                  cur_n = int'(bus.i2c_nbytes);
                  got_n.push_back(cur_n);
                  got_sa.push_back(int'(bus.i2c_slave_addr));
                  got_rw.push_back(int'(bus.i2c_rw));
                  nb = 0; bus.i2c_busy = 1'b1; gap = $urandom_range(0, 2); st = 1;
               end
               1: if (nb == cur_n) begin
                  tail = 2; st = 3;
               end else if (gap == 0) begin
                  bus.i2c_tx_data_req = 1'b1; st = 2;
               end else gap--;
               2: begin
                  got_data.push_back(bus.i2c_write_data);
                  nb++; bus.i2c_tx_data_req = 1'b0; gap = $urandom_range(0, 2); st = 1;
               end
               default: if (tail == 0) begin
                  bus.i2c_busy = 1'b0; fall_cyc = cyc; pend_page = 1'b1; st = 0;
               end else tail--;
            endcase
         end
      end
   end

   // Payload producer: offers the next byte whenever enabled and bytes remain.
   initial begin : producer
      data_in_valid = 1'b0; data_in = 8'h00; rdy_q = 1'b0;
      forever begin
         @(negedge clk);
         if (data_in_valid && rdy_q) pidx++;
         if (feed_en && pidx < pay_n) begin
            data_in_valid = 1'b1; data_in = pay[pidx];
         end else begin
            data_in_valid = 1'b0; data_in = 8'($urandom);
         end
         rdy_q = data_in_ready;
      end
   end

   task automatic clear_logs();
      got_n.delete(); got_sa.delete(); got_rw.delete(); got_data.delete();
      exp_n.delete(); exp_data.delete();
   endtask

   task automatic run_req(input logic [15:0] addr, input int n, input bit feed);
      int a, rem, c, k, d0;
      logic [6:0] sa;
      sa = 7'($urandom);
      clear_logs();
      for (int i = 0; i < n; i++) pay[i] = 8'($urandom);
      pay_n = n; pidx = 0; feed_en = feed;
      // Reference: split at page boundaries, address wraps at 64K, missing payload reads as FF.
      a = int'(addr); rem = n; k = 0;
      while (rem > 0) begin
         c = PAGE - (a % PAGE);
         if (c > rem) c = rem;
         exp_n.push_back(c + 2);
         exp_data.push_back(8'(a / 256));
         exp_data.push_back(8'(a % 256));
         for (int j = 0; j < c; j++) begin
            exp_data.push_back(feed ? pay[k] : 8'hFF);
            k++;
         end
         a = (a + c) % 65536;
         rem -= c;
      end
      d0 = done_cnt;
      @(negedge clk);
      slave_addr_w = sa; mem_addr_w = addr; write_nbytes_w = 8'(n); start = 1'b1;
      @(negedge clk);
      chk("busy_after_start", 32'(busy), 1);
      chk("underrun_cleared", 32'(underrun), 0);
      chk("done_low_after_start", 32'(done), 0);
      slave_addr_w = 7'($urandom); mem_addr_w = 16'($urandom); write_nbytes_w = 8'($urandom);
      @(negedge clk);
      start = 1'b0;
      if (n == 0) begin
         chk("zero_done_pulse", 32'(done), 1);
         chk("zero_busy_one_cycle", 32'(busy), 0);
      end
      for (int t = 0; t < 20000 && done_cnt == d0; t++) @(negedge clk);
      chk("done_seen", 32'(done_cnt != d0), 1);
      @(negedge clk);
      chk("done_is_pulse", 32'(done), 0);
      chk("idle_busy", 32'(busy), 0);
      chk("txn_count", got_n.size(), exp_n.size());
      for (int i = 0; i < exp_n.size() && i < got_n.size(); i++) begin
         chk("nbytes", got_n[i], exp_n[i]);
         chk("slave_addr", got_sa[i], int'(sa));
         chk("rw", got_rw[i], 0);
      end
      chk("byte_count", got_data.size(), exp_data.size());
      for (int i = 0; i < exp_data.size() && i < got_data.size(); i++)
         chk("byte", 32'(got_data[i]), 32'(exp_data[i]));
      chk("underrun_final", 32'(underrun), feed ? 0 : 1);
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_busy"}, 32'(busy), 0);
      chk({tag, "_done"}, 32'(done), 0);
      chk({tag, "_underrun"}, 32'(underrun), 0);
      chk({tag, "_ready"}, 32'(data_in_ready), 0);
      chk({tag, "_i2c_start"}, 32'(bus.i2c_start), 0);
      chk({tag, "_i2c_nbytes"}, 32'(bus.i2c_nbytes), 0);
      chk({tag, "_i2c_wdata"}, 32'(bus.i2c_write_data), 0);
      chk({tag, "_i2c_saddr"}, 32'(bus.i2c_slave_addr), 0);
      chk({tag, "_i2c_rw"}, 32'(bus.i2c_rw), 0);
   endtask

   initial begin : main
      logic [15:0] ra;
      reset = 1'b1; start = 1'b0;
      slave_addr_w = '0; mem_addr_w = '0; write_nbytes_w = '0;
      repeat (3) @(negedge clk);
      check_reset_outputs("reset");
      reset = 1'b0;
      repeat (2) @(negedge clk);

      run_req(16'h0010, 4, 1'b1);   // single page
      run_req(16'h003E, 6, 1'b1);   // crosses a page boundary
      run_req(16'h1234, 0, 1'b1);   // empty request
      run_req(16'h0200, 3, 1'b0);   // payload never supplied
      run_req(16'hFFFF, 2, 1'b1);   // address wrap

      // Reset in the middle of a data phase, then a fresh transfer.
      clear_logs();
      for (int i = 0; i < 10; i++) pay[i] = 8'($urandom);
      pay_n = 10; pidx = 0; feed_en = 1'b1;
      @(negedge clk);
      slave_addr_w = 7'h50; mem_addr_w = 16'h0100; write_nbytes_w = 8'd10; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int t = 0; t < 2000 && got_data.size() < 3; t++) @(negedge clk);
      chk("mid_send_reached", 32'(got_data.size() >= 3), 1);
      reset = 1'b1; feed_en = 1'b0;
      @(negedge clk);
      check_reset_outputs("midreset");
      @(negedge clk);
      reset = 1'b0;
      repeat (2) @(negedge clk);
      run_req(16'h0123, 5, 1'b1);

      for (int r = 0; r < 10; r++) begin
         ra = 16'($urandom);
         if ($urandom_range(0, 1) == 1) ra[2:0] = 3'(5 + $urandom_range(0, 2));
         if ($urandom_range(0, 3) == 0) ra[15:4] = 12'hFFF;
         run_req(ra, $urandom_range(0, 20), 1'b1);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
